// File: rtl/regfile_op_sequencer_pkg.sv
// regfile_op_sequencer_pkg: shared widths, instruction field layout, opcodes and FSM states
package regfile_op_sequencer_pkg;
  localparam int DATA_W  = 4;
  localparam int SEL_W   = 2;
  localparam int INSTR_W = 10;
  localparam int OP_LSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int RS1_LSB = 3;
  localparam int RS2_LSB = 1;
  typedef enum logic [2:0] {OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LDI} op_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;
  function automatic op_e instr_op(input logic [INSTR_W-1:0] i);
    return op_e'(i[OP_LSB+:3]);
  endfunction
  function automatic logic [SEL_W-1:0] instr_rd(input logic [INSTR_W-1:0] i);
    return i[RD_LSB+:SEL_W];
  endfunction
  function automatic logic [SEL_W-1:0] instr_rs1(input logic [INSTR_W-1:0] i);
    return i[RS1_LSB+:SEL_W];
  endfunction
  function automatic logic [SEL_W-1:0] instr_rs2(input logic [INSTR_W-1:0] i);
    return i[RS2_LSB+:SEL_W];
  endfunction
  // LDI immediate overlaps rs1/rs2 and the reserved bit
  function automatic logic [DATA_W-1:0] instr_imm(input logic [INSTR_W-1:0] i);
    return i[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/regfile_op_sequencer_alu.sv
// regfile_op_sequencer_alu: combinational ALU; carry is carry-out for ADD, borrow for SUB
module regfile_op_sequencer_alu
  import regfile_op_sequencer_pkg::*;
(
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] y,
  output logic              carry
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: {carry, y} = sum;
      OP_SUB: {carry, y} = diff;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_MOV: y = a;
      OP_LDI: y = imm;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: 4-cycle IDLE/READ/EXEC/WB controller, sole write master of a 4x4 register file.
// Define REGSEQ_FLAGS_EN to add the registered flag_z/flag_c outputs.
module regfile_op_sequencer
  import regfile_op_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [SEL_W-1:0]   read_sel1,
  output logic [SEL_W-1:0]   read_sel2,
  input  logic [DATA_W-1:0]  operand1,
  input  logic [DATA_W-1:0]  operand2,
  output logic [SEL_W-1:0]   write_sel,
  output logic [DATA_W-1:0]  write_data,
  output logic               write_enable,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result
`ifdef REGSEQ_FLAGS_EN
  ,
  output logic               flag_z,
  output logic               flag_c
`endif
);
  state_e              state, next;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_c;
  op_e                 op;
  assign op = instr_op(instr_q);
  regfile_op_sequencer_alu u_alu (
    .op    (op),
    .a     (op_a),
    .b     (op_b),
    .imm   (instr_imm(instr_q)),
    .y     (alu_y),
    .carry (alu_c)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      instr_q    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      read_sel1  <= '0;
      read_sel2  <= '0;
      write_sel  <= '0;
      write_data <= '0;
      result     <= '0;
    end else begin
      state <= next;
      if (state == S_IDLE && instr_valid) begin
        instr_q   <= instr;
        read_sel1 <= instr_rs1(instr);
        read_sel2 <= instr_rs2(instr);
      end
      if (state == S_READ) begin
        op_a <= operand1;
        op_b <= operand2;
      end
      if (state == S_EXEC) begin
        result     <= alu_y;
        write_sel  <= instr_rd(instr_q);
        write_data <= alu_y;
      end
    end
  end
`ifdef REGSEQ_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (state == S_EXEC && op != OP_NOP) begin
      flag_z <= alu_y == '0;
      flag_c <= alu_c;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = alu_c;
`endif
  // strobes decode from state so an async reset kills them immediately
  always_comb begin
    next         = state;
    instr_ready  = state == S_IDLE;
    busy         = state != S_IDLE;
    done         = state == S_WB;
    write_enable = state == S_WB && op != OP_NOP;
    case (state)
      S_IDLE: next = instr_valid ? S_READ : S_IDLE;
      S_READ: next = S_EXEC;
      S_EXEC: next = S_WB;
      S_WB:   next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb_regfile_op_sequencer: table-driven vectors plus back-to-back and reset-in-flight sequences
module tb_regfile_op_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [9:0] instr = '0;
  logic [1:0] read_sel1, read_sel2, write_sel;
  logic [3:0] operand1, operand2, write_data, result;
  logic       write_enable, busy, done;
`ifdef REGSEQ_FLAGS_EN
  logic       flag_z, flag_c;
`endif
  logic [3:0] rf [4];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_op_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .read_sel1    (read_sel1),
    .read_sel2    (read_sel2),
    .operand1     (operand1),
    .operand2     (operand2),
    .write_sel    (write_sel),
    .write_data   (write_data),
    .write_enable (write_enable),
    .busy         (busy),
    .done         (done),
    .result       (result)
`ifdef REGSEQ_FLAGS_EN
    ,
    .flag_z       (flag_z),
    .flag_c       (flag_c)
`endif
  );

  // register file model: combinational reads, synchronous write, resets to r_i = i
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf[0] <= 4'd0;
      rf[1] <= 4'd1;
      rf[2] <= 4'd2;
      rf[3] <= 4'd3;
    end else if (write_enable) begin
      rf[write_sel] <= write_data;
    end
  end
  assign operand1 = rf[read_sel1];
  assign operand2 = rf[read_sel2];

  typedef struct {
    string      name;
    logic [9:0] ins;
    logic       we;
    logic [1:0] sel;
    logic [3:0] data;
    logic       z;
    logic       c;
  } vec_t;

  function automatic logic [9:0] enc(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 1'b0};
  endfunction

  function automatic logic [9:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {3'd7, rd, 1'b0, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t t);
    int k;
    @(negedge clk);
    chk({t.name, " ready"}, 32'(instr_ready), 1);
    instr = t.ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    k = 1;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk({t.name, " latency"}, k, 3);
    chk({t.name, " we"}, 32'(write_enable), 32'(t.we));
    if (t.we) begin
      chk({t.name, " sel"}, 32'(write_sel), 32'(t.sel));
      chk({t.name, " data"}, 32'(write_data), 32'(t.data));
      chk({t.name, " result"}, 32'(result), 32'(t.data));
    end
`ifdef REGSEQ_FLAGS_EN
    chk({t.name, " flags"}, {30'd0, flag_z, flag_c}, {30'd0, t.z, t.c});
`endif
    @(negedge clk);
    chk({t.name, " strobe width"}, {30'd0, done, write_enable}, 0);
  endtask

  initial begin
    vec_t v[10];
    logic [9:0] q[3];
    logic [1:0] qs[3];
    logic [3:0] qd[3];
    int idx, di, last, cnt;
    v[0] = '{"add r0,r2,r3", enc(3'd1, 2'd0, 2'd2, 2'd3), 1'b1, 2'd0, 4'h5, 1'b0, 1'b0};
    v[1] = '{"ldi r3,f",     ldi(2'd3, 4'hF),            1'b1, 2'd3, 4'hF, 1'b0, 1'b0};
    v[2] = '{"add wrap",     enc(3'd1, 2'd3, 2'd3, 2'd1), 1'b1, 2'd3, 4'h0, 1'b1, 1'b1};
    v[3] = '{"sub r1,r1,r2", enc(3'd2, 2'd1, 2'd1, 2'd2), 1'b1, 2'd1, 4'hF, 1'b0, 1'b1};
    v[4] = '{"and r2,r1,r0", enc(3'd3, 2'd2, 2'd1, 2'd0), 1'b1, 2'd2, 4'h5, 1'b0, 1'b0};
    v[5] = '{"xor r0,r0,r2", enc(3'd5, 2'd0, 2'd0, 2'd2), 1'b1, 2'd0, 4'h0, 1'b1, 1'b0};
    v[6] = '{"nop",          enc(3'd0, 2'd2, 2'd1, 2'd1), 1'b0, 2'd2, 4'h0, 1'b1, 1'b0};
    v[7] = '{"or r3,r1,r2",  enc(3'd4, 2'd3, 2'd1, 2'd2), 1'b1, 2'd3, 4'hF, 1'b0, 1'b0};
    v[8] = '{"mov r0,r2",    enc(3'd6, 2'd0, 2'd2, 2'd0), 1'b1, 2'd0, 4'h5, 1'b0, 1'b0};
    v[9] = '{"sub borrow",   enc(3'd2, 2'd1, 2'd2, 2'd1), 1'b1, 2'd1, 4'h6, 1'b0, 1'b1};
    q[0] = enc(3'd6, 2'd0, 2'd1, 2'd0); qs[0] = 2'd0; qd[0] = 4'h6;
    q[1] = enc(3'd1, 2'd2, 2'd0, 2'd0); qs[1] = 2'd2; qd[1] = 4'hC;
    q[2] = enc(3'd5, 2'd3, 2'd2, 2'd1); qs[2] = 2'd3; qd[2] = 4'hA;

    repeat (2) @(negedge clk);
    chk("reset ready", 32'(instr_ready), 1);
    chk("reset strobes", {29'd0, busy, done, write_enable}, 0);
    chk("reset sels", {26'd0, read_sel1, read_sel2, write_sel}, 0);
    chk("reset data", {24'd0, write_data, result}, 0);
`ifdef REGSEQ_FLAGS_EN
    chk("reset flags", {30'd0, flag_z, flag_c}, 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run(v[i]);
    chk("rf after table", {16'd0, rf[3], rf[2], rf[1], rf[0]}, 32'hF565);

    idx = 0; di = 0; last = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (done) begin
        if (di < 3) begin
          chk("b2b sel", 32'(write_sel), 32'(qs[di]));
          chk("b2b data", 32'(write_data), 32'(qd[di]));
        end
        di++;
      end
      if (instr_ready) begin
        if (idx < 3) begin
          if (idx > 0) chk("b2b ready gap", cyc - last, 4);
          last = cyc;
          instr = q[idx];
          instr_valid = 1'b1;
          idx++;
        end else begin
          instr_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("b2b accepted", idx, 3);
    chk("b2b done count", di, 3);
    chk("rf after b2b", {16'd0, rf[3], rf[2], rf[1], rf[0]}, 32'hAC66);

    instr = enc(3'd6, 2'd0, 2'd3, 2'd0);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mov in exec busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("async reset we", {30'd0, write_enable, done}, 0);
    chk("async reset ready", {30'd0, instr_ready, busy}, 32'h2);
    chk("async reset outs", {22'd0, write_sel, read_sel1, write_data, result}, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += int'(write_enable) + int'(done);
    end
    chk("no write after reset", cnt, 0);
    chk("r0 after reset", 32'(rf[0]), 0);
    chk("ready after reset", 32'(instr_ready), 1);

    run('{"add after reset", enc(3'd1, 2'd1, 2'd2, 2'd3), 1'b1, 2'd1, 4'h5, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
